gf2m_inv: RTL and testbench
===========================

GF2M_INV -- requirements
Module: gf2m_inv

Interface
REQ-001 SHALL have parameter M, default 8: field width, GF(2^M), legal range 3..16.
REQ-002 SHALL have parameter POLY, default 8'h1D: low M bits of the primitive polynomial; the x^M term is implicit.
REQ-003 SHALL have port i_clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1 bit: sample operands and begin an operation.
REQ-006 SHALL have port x, input, M bits: operand to invert.
REQ-007 SHALL have port y, output, M bits: result.
REQ-008 SHALL have port o_ready, output, 1 bit: y valid.
REQ-009 SHALL have port o_busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port o_zero, output, 1 bit: the last sampled x was 0.

Function
REQ-011 SHALL compute y = x^(2^M-2), i.e. 1/x in GF(2^M) modulo POLY, by iterated squaring and multiply-accumulate, one square plus one multiply per cycle.
REQ-012 SHALL contain an internal, combinational, parametrised GF(2^M) multiplier reduced by POLY; the squarer is the same multiplier with both inputs tied together.
REQ-013 SHALL have three states: IDLE, RUN and DONE.
REQ-014 Start edge: SHALL load square register = x*x, accumulator = init value (REQ-030/031), counter = 0, o_zero = (x==0), and enter RUN. Accepted in any state.
REQ-015 RUN, each edge: accumulator <= accumulator*square; square <= square*square; counter += 1. When counter reaches M-1, SHALL enter DONE.
REQ-016 Latency: o_ready SHALL rise exactly M-1 clocks after the start edge (7 clocks for M=8).
REQ-017 o_busy SHALL be 1 only in RUN; o_ready SHALL be 1 only in DONE; the two SHALL never both be 1.
REQ-018 y SHALL equal the accumulator at all times; it SHALL be stable and valid throughout DONE.
REQ-019 DONE SHALL hold, with no state change, until the next start or reset.
REQ-020 i_start during RUN SHALL abort the current operation and restart with the new x; no o_ready pulse SHALL occur for the aborted operation.
REQ-021 i_start during DONE SHALL drop o_ready on that edge and begin a new operation.
REQ-022 x=0: SHALL run full latency; result y=0 (the init value times 0) with o_zero=1; o_zero SHALL hold until the next start.
REQ-023 x SHALL be sampled only on the start edge; changes to x during RUN or DONE SHALL be ignored.
REQ-024 Counter width SHALL be ceil(log2(M)) bits; it SHALL never wrap, holding at M-1 in DONE.

Reset
REQ-025 i_rst=1 at a clock edge SHALL force IDLE, with y=0, o_ready=0, o_busy=0, o_zero=0, counter=0 and square=0.
REQ-026 i_rst SHALL take priority over i_start on the same edge.
REQ-027 Reset mid-RUN SHALL discard the operation; no o_ready SHALL follow.
REQ-028 After reset release, outputs SHALL stay at reset values until the first start edge.

Configuration
REQ-029 Macro GF2M_INV_DIV_EN SHALL select division mode.
REQ-030 Macro defined: SHALL add input port n (M bits, dividend) sampled on the start edge; the accumulator init value SHALL be n, giving y = n/x after the same latency; x=0 SHALL give y=0 with o_zero=1.
REQ-031 Macro undefined: port n SHALL be absent and the accumulator init value SHALL be 1 (pure inverse).

Verification
REQ-032 M=8, POLY=0x1D, start with x=0x02 -> o_ready high 7 clocks later, y=0x8E, o_zero=0.
REQ-033 M=8, x=0x01 -> y=0x01; then x=0x00 -> y=0x00, o_zero=1 at o_ready.
REQ-034 M=4, POLY=0x3, x=0x2 -> o_ready 3 clocks later, y=0x9.
REQ-035 M=8: start x=0x02, then at cycle 3 restart with x=0x01 -> no o_ready at cycle 7; o_ready at cycle 10 with y=0x01.
REQ-036 M=8: start x=0x02, i_rst at cycle 4 -> y=0, o_busy=0, o_ready stays 0 for 20 cycles.
REQ-037 GF2M_INV_DIV_EN defined, M=8: n=0x04, x=0x02 -> y=0x02 after 7 clocks; all 255 nonzero x with n=0x01 -> y*x=0x01.

Source files
------------

// File: rtl/gf2m_inv.sv
// Iterative GF(2^M) inverter: y = x^(2^M-2) by repeated squaring and multiply-accumulate.
// Define GF2M_INV_DIV_EN for division mode, which adds dividend port n and gives y = n/x.
module gf2m_inv #(
  parameter int          M    = 8,
  parameter logic [15:0] POLY = 16'h001D
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [M-1:0] x,
`ifdef GF2M_INV_DIV_EN
  input  logic [M-1:0] n,
`endif
  output logic [M-1:0] y,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_zero
);

  localparam int          CW   = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  acc, acc_nxt;
  logic [M-1:0]  sq, sq_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          zero_r, zero_nxt;
  logic [M-1:0]  init_val;

  // Shift-and-add multiply, reducing by the implicit x^M term after every shift.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ t;
      t = t[M-1] ? ((t << 1) ^ POLY[M-1:0]) : (t << 1);
    end
    return p;
  endfunction

`ifdef GF2M_INV_DIV_EN
  assign init_val = n;
`else
  assign init_val = M'(1);
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    sq_nxt    = sq;
    cnt_nxt   = cnt;
    zero_nxt  = zero_r;
    if (i_start) begin
      sq_nxt    = gf_mul(x, x);
      acc_nxt   = init_val;
      cnt_nxt   = '0;
      zero_nxt  = (x == '0);
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          acc_nxt = gf_mul(acc, sq);
          sq_nxt  = gf_mul(sq, sq);
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST - CW'(1)) state_nxt = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      acc    <= '0;
      sq     <= '0;
      cnt    <= '0;
      zero_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      sq     <= sq_nxt;
      cnt    <= cnt_nxt;
      zero_r <= zero_nxt;
    end
  end

  assign y       = acc;
  assign o_busy  = (state == RUN);
  assign o_ready = (state == DONE);
  assign o_zero  = zero_r;

endmodule

// File: tb/tb_gf2m_inv.sv
// Self-checking bench for gf2m_inv: M=8/POLY=0x1D instance with a log/antilog scoreboard
// model, plus an M=4/POLY=0x3 instance checked against constants.
module tb_gf2m_inv;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [7:0] x, y;
  logic       rdy, busy, zero;
  logic       s4;
  logic [3:0] x4, y4;
  logic       rdy4, busy4, zero4;
`ifdef GF2M_INV_DIV_EN
  logic [7:0] n;
  logic [3:0] n4;
`endif

  int checks = 0;
  int failures = 0;

  int exp8[0:254];
  int log8[0:255];
  logic [7:0] exp_q[$];
  logic       zexp_q[$];

  gf2m_inv #(.M(8), .POLY(16'h001D)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .x(x),
`ifdef GF2M_INV_DIV_EN
    .n(n),
`endif
    .y(y), .o_ready(rdy), .o_busy(busy), .o_zero(zero)
  );

  gf2m_inv #(.M(4), .POLY(16'h0003)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(s4), .x(x4),
`ifdef GF2M_INV_DIV_EN
    .n(n4),
`endif
    .y(y4), .o_ready(rdy4), .o_busy(busy4), .o_zero(zero4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_div(input int nn, input int xx);
    if (xx == 0 || nn == 0) return 8'h00;
    return 8'(exp8[(log8[nn] - log8[xx] + 255) % 255]);
  endfunction

  task automatic start_op(input logic [7:0] xv, input logic [7:0] nv);
    x = xv;
`ifdef GF2M_INV_DIV_EN
    n = nv;
    exp_q.push_back(model_div(nv, xv));
`else
    exp_q.push_back(model_div(1, xv));
`endif
    zexp_q.push_back(xv == 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_check(input string tag);
    int k;
    logic [7:0] ev;
    logic ez;
    k = 0;
    while (!rdy && k < 20) begin
      tick();
      k++;
    end
    ev = exp_q.pop_front();
    ez = zexp_q.pop_front();
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL %s timeout: o_ready=%b required 1", tag, rdy);
    end else if (y !== ev || zero !== ez) begin
      failures++;
      $display("FAIL %s: y=%h o_zero=%b required y=%h o_zero=%b", tag, y, zero, ev, ez);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; x = 8'h02; s4 = 1'b1; x4 = 4'h2;
`ifdef GF2M_INV_DIV_EN
    n = 8'h01; n4 = 4'h1;
`endif
    tick(); tick();
    rst = 1'b0; start = 1'b0; s4 = 1'b0;
    checks++;
    if ({y, rdy, busy, zero} !== 11'b0) begin
      failures++;
      $display("FAIL reset8: y=%h rdy=%b busy=%b zero=%b required all 0", y, rdy, busy, zero);
    end
    checks++;
    if ({y4, rdy4, busy4, zero4} !== 7'b0) begin
      failures++;
      $display("FAIL reset4: y=%h rdy=%b busy=%b zero=%b required all 0", y4, rdy4, busy4, zero4);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({y, rdy, busy, zero} !== 11'b0) begin
      failures++;
      $display("FAIL reset_hold: y=%h rdy=%b busy=%b zero=%b required all 0", y, rdy, busy, zero);
    end
  endtask

  task automatic test_known();
    start_op(8'h02, 8'h01);
    x = 8'h55;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (c < 7 && (rdy !== 1'b0 || busy !== 1'b1)) begin
        failures++;
        $display("FAIL latency c=%0d: rdy=%b busy=%b required 0/1", c, rdy, busy);
      end else if (c == 7 && (rdy !== 1'b1 || busy !== 1'b0)) begin
        failures++;
        $display("FAIL latency c=7: rdy=%b busy=%b required 1/0", rdy, busy);
      end
    end
    checks++;
    if (y !== 8'h8E || zero !== 1'b0) begin
      failures++;
      $display("FAIL inv2_const: y=%h zero=%b required 8e 0", y, zero);
    end
    wait_check("inv2");
    for (int i = 0; i < 5; i++) begin
      x = 8'(i * 37);
      tick();
    end
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || y !== 8'h8E) begin
      failures++;
      $display("FAIL done_hold: rdy=%b busy=%b y=%h required 1 0 8e", rdy, busy, y);
    end
  endtask

  task automatic test_one_zero();
    start_op(8'h01, 8'h01);
    wait_check("inv1");
    start_op(8'h00, 8'h01);
    wait_check("inv0");
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (zero !== 1'b1 || y !== 8'h00) begin
      failures++;
      $display("FAIL zero_hold: zero=%b y=%h required 1 00", zero, y);
    end
    start_op(8'h03, 8'h01);
    checks++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL zero_clear: zero=%b required 0", zero);
    end
    wait_check("inv3");
  endtask

  task automatic test_back_to_back();
    start_op(8'h01, 8'h01);
    wait_check("b2b_1");
    for (int xv = 2; xv < 256; xv++) begin
      start_op(8'(xv), 8'h01);
      checks++;
      if (rdy !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL restart_from_done x=%h: rdy=%b busy=%b required 0 1", xv[7:0], rdy, busy);
      end
      wait_check("b2b");
    end
  endtask

  task automatic test_abort();
    start_op(8'h02, 8'h01);
    tick(); tick();
    exp_q.delete(); zexp_q.delete();
    start_op(8'h01, 8'h01);
    for (int c = 4; c <= 10; c++) begin
      tick();
      checks++;
      if (c < 10 && rdy !== 1'b0) begin
        failures++;
        $display("FAIL abort c=%0d: rdy=%b required 0", c, rdy);
      end else if (c == 10 && (rdy !== 1'b1 || y !== 8'h01)) begin
        failures++;
        $display("FAIL abort_result: rdy=%b y=%h required 1 01", rdy, y);
      end
    end
    exp_q.delete(); zexp_q.delete();
  endtask

  task automatic test_rst_mid();
    logic seen;
    start_op(8'h02, 8'h01);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (y !== 8'h00 || busy !== 1'b0 || rdy !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: y=%h busy=%b rdy=%b zero=%b required 00 0 0 0", y, busy, rdy, zero);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rdy !== 1'b0 || y !== 8'h00) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_mid_quiet: activity=%b required 0", seen);
    end
    exp_q.delete(); zexp_q.delete();
  endtask

  task automatic run4(input logic [3:0] xv, input logic [3:0] ev, input logic ez);
    x4 = xv;
`ifdef GF2M_INV_DIV_EN
    n4 = 4'h1;
`endif
    s4 = 1'b1;
    tick();
    s4 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (c < 3 && rdy4 !== 1'b0) begin
        failures++;
        $display("FAIL m4 x=%h c=%0d: rdy=%b required 0", xv, c, rdy4);
      end else if (c == 3 && (rdy4 !== 1'b1 || y4 !== ev || zero4 !== ez)) begin
        failures++;
        $display("FAIL m4 x=%h: rdy=%b y=%h zero=%b required 1 %h %b", xv, rdy4, y4, zero4, ev, ez);
      end
    end
  endtask

  task automatic test_m4();
    run4(4'h2, 4'h9, 1'b0);
    run4(4'h9, 4'h2, 1'b0);
    run4(4'h1, 4'h1, 1'b0);
    run4(4'h3, 4'hE, 1'b0);
    run4(4'h0, 4'h0, 1'b1);
  endtask

`ifdef GF2M_INV_DIV_EN
  task automatic test_div();
    int prod;
    start_op(8'h02, 8'h04);
    checks++;
    wait_check("div4_2");
    if (y !== 8'h02) begin
      failures++;
      $display("FAIL div_const: y=%h required 02", y);
    end
    for (int xv = 1; xv < 256; xv++) begin
      start_op(8'(xv), 8'h01);
      wait_check("div_inv");
      prod = (y == 8'h00) ? 0 : exp8[(log8[y] + log8[xv]) % 255];
      checks++;
      if (prod != 1) begin
        failures++;
        $display("FAIL div_prod x=%h: y*x=%h required 01", xv[7:0], prod[7:0]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_check("div_rand");
    end
    start_op(8'h00, 8'h37);
    wait_check("div_x0");
  endtask
`endif

  initial begin
    int e;
    e = 1;
    for (int i = 0; i < 256; i++) log8[i] = 0;
    for (int i = 0; i < 255; i++) begin
      exp8[i] = e;
      log8[e] = i;
      e = e << 1;
      if (e & 256) e = e ^ 'h11D;
    end
    rst = 1'b0; start = 1'b0; x = 8'h00; s4 = 1'b0; x4 = 4'h0;
`ifdef GF2M_INV_DIV_EN
    n = 8'h01; n4 = 4'h1;
`endif
    test_reset();
    test_known();
    test_one_zero();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_m4();
`ifdef GF2M_INV_DIV_EN
    test_div();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
